// File: rtl/peridot_csr_spi_bytemaster.sv
// Byte-wide SPI master (mode 0, MSB first) behind a single 32-bit control register.
// Host owns select level; each start write shifts one byte out and one byte in.
module peridot_csr_spi_bytemaster #(
  parameter int unsigned CLOCK_DIVIDER = 2
) (
  input  logic        clock_sig,
  input  logic        reset_sig,
  input  logic        ctrl_write,
  input  logic [31:0] ctrl_writedata,
  output logic [31:0] ctrl_readdata,
  output logic        spi_ss_n,
  output logic        spi_sclk,
  output logic        spi_mosi,
  input  logic        spi_miso
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SHIFT_LO = 2'd1,
    SHIFT_HI = 2'd2
  } state_e;

  localparam logic [7:0] DIV_LAST = 8'(CLOCK_DIVIDER - 1);

  state_e     state_q, state_d;
  logic [7:0] div_q, div_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] tx_q, tx_d;
  logic [7:0] rx_q, rx_d;
  logic [7:0] rxd_q, rxd_d;
  logic       sso_q, sso_d;
  logic       mosi_q, mosi_d;
  logic       rdy;

  always_ff @(posedge clock_sig or posedge reset_sig) begin
    if (reset_sig) begin
      state_q <= IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      rxd_q   <= '0;
      sso_q   <= 1'b0;
      mosi_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      rxd_q   <= rxd_d;
      sso_q   <= sso_d;
      mosi_q  <= mosi_d;
    end
  end

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    rxd_d   = rxd_q;
    sso_d   = sso_q;
    mosi_d  = mosi_q;
    unique case (state_q)
      IDLE: begin
        if (ctrl_write) begin
          sso_d = ctrl_writedata[8];
          if (ctrl_writedata[9]) begin
            tx_d    = ctrl_writedata[7:0];
            mosi_d  = ctrl_writedata[7];
            div_d   = DIV_LAST;
            bit_d   = 3'd7;
            state_d = SHIFT_LO;
          end
        end
      end
      SHIFT_LO: begin
        if (div_q == 8'd0) begin
          div_d   = DIV_LAST;
          rx_d    = {rx_q[6:0], spi_miso};
          state_d = SHIFT_HI;
        end else begin
          div_d = div_q - 8'd1;
        end
      end
      SHIFT_HI: begin
        if (div_q == 8'd0) begin
          div_d = DIV_LAST;
          // MOSI keeps the last bit after the final falling edge
          if (bit_q == 3'd0) begin
            rxd_d   = rx_q;
            state_d = IDLE;
          end else begin
            bit_d   = bit_q - 3'd1;
            tx_d    = {tx_q[6:0], 1'b0};
            mosi_d  = tx_q[6];
            state_d = SHIFT_LO;
          end
        end else begin
          div_d = div_q - 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign rdy           = (state_q == IDLE);
  assign ctrl_readdata = {22'd0, rdy, sso_q, rxd_q};
  assign spi_ss_n      = ~sso_q;
  assign spi_sclk      = (state_q == SHIFT_HI);
  assign spi_mosi      = mosi_q;

endmodule
